// File: rtl/signed_div_ctrl_if.sv
// Handshake/data bundle between the signed divide front-end, the multdiv
// consumer and the unsigned iterative divider.
//   ctrl_DIV, data_operandA/B          : request strobe and signed operands
//   data_quotient/remainder/exception  : signed result and divide-by-zero flag
//   data_resultRDY, data_busy          : result-valid pulse, operation in flight
//   div_start, div_operandA/B          : launch pulse and magnitudes to divider
//   div_quotient/remainder/resultRDY   : unsigned result and completion pulse
// The slave modport is the sequencer's view; master is the surrounding system.
interface signed_div_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_quotient;
  logic [WIDTH-1:0] data_remainder;
  logic             data_exception;
  logic             data_resultRDY;
  logic             data_busy;
  logic             div_start;
  logic [WIDTH-1:0] div_operandA;
  logic [WIDTH-1:0] div_operandB;
  logic [WIDTH-1:0] div_quotient;
  logic [WIDTH-1:0] div_remainder;
  logic             div_resultRDY;

  modport slave (
    input  ctrl_DIV, data_operandA, data_operandB,
    input  div_quotient, div_remainder, div_resultRDY,
    output data_quotient, data_remainder, data_exception, data_resultRDY, data_busy,
    output div_start, div_operandA, div_operandB
  );

  modport master (
    output ctrl_DIV, data_operandA, data_operandB,
    output div_quotient, div_remainder, div_resultRDY,
    input  data_quotient, data_remainder, data_exception, data_resultRDY, data_busy,
    input  div_start, div_operandA, div_operandB
  );
endinterface

// File: rtl/signed_div_ctrl.sv
// Signed front-end sequencer for an unsigned iterative divider.
// Takes a signed request, hands operand magnitudes to the divider, waits for
// its completion pulse and sign-corrects the quotient (truncated toward zero)
// and remainder (sign of the dividend). Divide-by-zero skips the divider and
// returns quotient 0, remainder = dividend, exception = 1.
// Ports:
//   clock : posedge clock
//   reset : synchronous active-high reset
//   bus   : signed_div_ctrl_if slave modport (request, result, divider side)
module signed_div_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                clock,
  input  logic                reset,
  signed_div_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWait,
    StFix,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [WIDTH-1:0] mag_a_q, mag_a_d;
  logic [WIDTH-1:0] mag_b_q, mag_b_d;
  logic [WIDTH-1:0] q_raw_q, q_raw_d;
  logic [WIDTH-1:0] r_raw_q, r_raw_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             exc_q, exc_d;

  // Modulo-2^WIDTH negation; |most-negative| stays most-negative, read unsigned.
  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
    return '0 - v;
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? neg(v) : v;
  endfunction

  always_comb begin
    state_d  = state_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    q_raw_d  = q_raw_q;
    r_raw_d  = r_raw_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    exc_d    = exc_q;

    if (bus.ctrl_DIV) begin
      // A new request in any state abandons whatever was in flight.
      sign_a_d = bus.data_operandA[WIDTH-1];
      sign_b_d = bus.data_operandB[WIDTH-1];
      mag_a_d  = mag(bus.data_operandA);
      mag_b_d  = mag(bus.data_operandB);
      if (bus.data_operandB == '0) begin
        quot_d  = '0;
        rem_d   = bus.data_operandA;
        exc_d   = 1'b1;
        state_d = StDone;
      end else begin
        state_d = StStart;
      end
    end else begin
      unique case (state_q)
        StIdle:  state_d = StIdle;
        StStart: state_d = StWait;
        StWait: begin
          if (bus.div_resultRDY) begin
            q_raw_d = bus.div_quotient;
            r_raw_d = bus.div_remainder;
            state_d = StFix;
          end
        end
        StFix: begin
          quot_d  = (sign_a_q ^ sign_b_q) ? neg(q_raw_q) : q_raw_q;
          rem_d   = sign_a_q ? neg(r_raw_q) : r_raw_q;
          exc_d   = 1'b0;
          state_d = StDone;
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      q_raw_q  <= '0;
      r_raw_q  <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      q_raw_q  <= q_raw_d;
      r_raw_q  <= r_raw_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      exc_q    <= exc_d;
    end
  end

  // Magnitude registers feed the divider directly, so they stay stable until
  // the next request or reset.
  assign bus.div_operandA   = mag_a_q;
  assign bus.div_operandB   = mag_b_q;
  assign bus.div_start      = (state_q == StStart);
  assign bus.data_resultRDY = (state_q == StDone);
  assign bus.data_busy      = (state_q != StIdle);
  assign bus.data_quotient  = quot_q;
  assign bus.data_remainder = rem_q;
  assign bus.data_exception = exc_q;

endmodule

// File: tb/tb_signed_div_ctrl.sv
module tb_signed_div_ctrl;
  localparam int unsigned W   = 32;
  localparam int          Lat = 33;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  signed_div_ctrl_if #(.WIDTH(W)) bus ();
  signed_div_ctrl #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: plain signed 64-bit arithmetic truncated back to 32 bits.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic e);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) begin
      q = 32'd0; r = a; e = 1'b1;
    end else begin
      q = 32'(sa / sb); r = 32'(sa % sb); e = 1'b0;
    end
  endfunction

  function automatic logic [31:0] absv(input logic [31:0] v);
    return v[31] ? 32'd0 - v : v;
  endfunction

  // Unsigned divider model: fixed or per-op latency, restarts on div_start.
  int          lat_cur  = Lat;
  int          div_cnt  = 0;
  logic [31:0] da, db;
  int          n_starts = 0;
  int          n_pulses = 0;
  int          last_pulse_cyc = -1;

  always @(negedge clock) begin
    bus.div_resultRDY = 1'b0;
    if (bus.div_start) begin
      div_cnt = lat_cur;
      da = bus.div_operandA;
      db = bus.div_operandB;
      n_starts++;
    end else if (div_cnt > 0) begin
      div_cnt--;
      if (div_cnt == 0) begin
        bus.div_resultRDY = 1'b1;
        bus.div_quotient  = (db == 0) ? 32'hFFFF_FFFF : da / db;
        bus.div_remainder = (db == 0) ? da : da % db;
        last_pulse_cyc = cyc;
        n_pulses++;
      end
    end
  end

  // Transaction-level model of what the consumer must observe.
  bit          mvalid = 1'b0;
  bit          pend   = 1'b0;
  int          rdy_due = -1;
  int          start_due = -1;
  int          req_cyc = 0;
  logic [31:0] pend_q, pend_r, held_q, held_r, exp_mag_a, exp_mag_b;
  logic        pend_e, held_e;

  always @(posedge clock) begin
    if (reset) begin
      mvalid = 1'b1; pend = 1'b0; rdy_due = -1; start_due = -1;
      held_q = 0; held_r = 0; held_e = 0; exp_mag_a = 0; exp_mag_b = 0;
    end else if (mvalid) begin
      if (rdy_due == cyc) begin
        held_q = pend_q; held_r = pend_r; held_e = pend_e;
        pend = 1'b0; rdy_due = -1;
      end
      if (bus.ctrl_DIV) begin
        ref_div(bus.data_operandA, bus.data_operandB, pend_q, pend_r, pend_e);
        exp_mag_a = absv(bus.data_operandA);
        exp_mag_b = absv(bus.data_operandB);
        pend = 1'b1; req_cyc = cyc;
        if (bus.data_operandB == 0) begin
          rdy_due = cyc + 1; start_due = -1;
        end else begin
          rdy_due = -1; start_due = cyc + 1;
        end
      end else if (bus.div_resultRDY && pend && rdy_due == -1 && cyc >= req_cyc + 2) begin
        rdy_due = cyc + 2;
      end
    end
    cyc++;
  end

  int n_rdy = 0;
  always @(negedge clock) begin
    if (mvalid) begin
      logic exp_rdy;
      exp_rdy = (rdy_due == cyc);
      if (bus.data_resultRDY) n_rdy++;
      chk("resultRDY", bus.data_resultRDY, exp_rdy);
      chk("busy", bus.data_busy, pend);
      chk("div_start", bus.div_start, start_due == cyc);
      chk("div_operandA", bus.div_operandA, exp_mag_a);
      chk("div_operandB", bus.div_operandB, exp_mag_b);
      chk("quotient", bus.data_quotient, exp_rdy ? pend_q : held_q);
      chk("remainder", bus.data_remainder, exp_rdy ? pend_r : held_r);
      chk("exception", bus.data_exception, exp_rdy ? pend_e : held_e);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] b);
    bus.ctrl_DIV = 1'b1; bus.data_operandA = a; bus.data_operandB = b;
    tick();
    bus.ctrl_DIV = 1'b0;
  endtask

  task automatic wait_rdy(input string nm, output bit ok, output int at,
                          output logic [31:0] q, output logic [31:0] r, output logic e);
    ok = 1'b0; at = -1; q = 0; r = 0; e = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (bus.data_resultRDY) begin
        ok = 1'b1; at = cyc;
        q = bus.data_quotient; r = bus.data_remainder; e = bus.data_exception;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL %s timeout: no data_resultRDY within 100 cycles, required one", nm);
    end
    tick();
  endtask

  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic ee,
                        output int at);
    bit ok;
    logic [31:0] q, r;
    logic e;
    req(a, b);
    wait_rdy(nm, ok, at, q, r, e);
    if (ok) begin
      chk({nm, " q"}, q, eq);
      chk({nm, " r"}, r, er);
      chk({nm, " exc"}, e, ee);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int at, c0, s0, r0, p0;
    bit ok;
    logic [31:0] q, r, a, b;
    logic e;
    reset = 1'b1;
    bus.ctrl_DIV = 1'b0; bus.data_operandA = 0; bus.data_operandB = 0;
    tick(); tick();
    reset = 1'b0;
    @(negedge clock);
    chk("reset busy", bus.data_busy, 1'b0);
    chk("reset quotient", bus.data_quotient, 32'd0);
    chk("reset rdy", bus.data_resultRDY, 1'b0);
    tick();

    // Basic op, latency, sign combinations.
    run_op("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, at);
    chk("rdy latency", 32'(at - last_pulse_cyc), 32'd2);
    run_op("-100/7", -32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, at);
    run_op("100/-7", 32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0, at);
    run_op("-100/-7", -32'sd100, -32'sd7, 32'd14, 32'hFFFF_FFFE, 1'b0, at);

    // Divide by zero.
    s0 = n_starts; c0 = cyc;
    run_op("0x1234/0", 32'h1234, 32'd0, 32'd0, 32'h1234, 1'b1, at);
    chk("dbz latency", 32'(at - c0), 32'd1);
    chk("dbz no start", 32'(n_starts - s0), 32'd0);
    run_op("9/3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, at);

    // Extremes.
    run_op("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, at);
    run_op("min/2", 32'h8000_0000, 32'd2, 32'hC000_0000, 32'd0, 1'b0, at);
    run_op("7/100", 32'd7, 32'd100, 32'd0, 32'd7, 1'b0, at);

    // Restart in WAIT cycle 10.
    s0 = n_starts; r0 = n_rdy;
    req(32'd50, 32'd5);
    repeat (10) tick();
    run_op("restart 81/-9", 32'd81, -32'sd9, 32'hFFFF_FFF7, 32'd0, 1'b0, at);
    chk("restart starts", 32'(n_starts - s0), 32'd2);
    chk("restart single rdy", 32'(n_rdy - r0), 32'd1);

    // Reset mid-WAIT, stale divider pulse must be ignored.
    req(32'd1000, 32'd3);
    repeat (19) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("abort busy", bus.data_busy, 1'b0);
    chk("abort quotient", bus.data_quotient, 32'd0);
    chk("abort operandA", bus.div_operandA, 32'd0);
    tick();
    r0 = n_rdy; p0 = n_pulses;
    repeat (20) tick();
    chk("stale pulse seen", 32'(n_pulses - p0), 32'd1);
    chk("stale pulse no rdy", 32'(n_rdy - r0), 32'd0);
    run_op("20/4", 32'd20, 32'd4, 32'd5, 32'd0, 1'b0, at);
    run_op("-21/4", -32'sd21, 32'd4, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0, at);

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int n = 0; n < 250; n++) begin
      int mode;
      a = ($urandom_range(3) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 20);
        3:       b = -$urandom_range(1, 20);
        default: b = $urandom;
      endcase
      lat_cur = $urandom_range(1, 40);
      mode = $urandom_range(3);
      req(a, b);
      if (mode == 0) begin
        repeat ($urandom_range(0, lat_cur + 3)) tick();
        req($urandom, $urandom_range(1, 1000));
      end else if (mode == 1 && b != 0) begin
        p0 = n_pulses;
        for (int i = 0; i < 100 && n_pulses == p0; i++) @(negedge clock);
        tick(); tick();
        req($urandom, $urandom);
      end
      wait_rdy("random", ok, at, q, r, e);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/signed_div_ctrl.md
Name: signed_div_ctrl

Overview:
- Signed front-end sequencer that sits directly upstream of the unsigned 32-bit iterative divider.
- Accepts a signed divide request and converts both operands to magnitudes.
- Launches the divider and holds its operands stable for the whole operation, waits for the divider's ready pulse, then sign-corrects the quotient and remainder.
- Presents the final result to the multdiv consumer with a one-cycle ready pulse.
- Divide-by-zero is short-circuited without starting the divider.

Parameters:
- WIDTH, 32, operand/result width in bits (two's complement at this block's ports, unsigned at the divider side).

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- ctrl_DIV  input  1  request strobe; operands sampled in the same cycle.
- data_operandA  input  WIDTH  signed dividend.
- data_operandB  input  WIDTH  signed divisor.
- data_quotient  output  WIDTH  signed quotient, truncated toward zero.
- data_remainder  output  WIDTH  signed remainder; sign follows the dividend.
- data_exception  output  1  divide-by-zero flag for the current result.
- data_resultRDY  output  1  one-cycle pulse: result valid.
- data_busy  output  1  high from the cycle after ctrl_DIV until the cycle data_resultRDY is high, inclusive.
- div_start  output  1  one-cycle launch pulse to the divider.
- div_operandA  output  WIDTH  |A|, registered, held stable from div_start until div_resultRDY.
- div_operandB  output  WIDTH  |B|, registered, held stable likewise.
- div_quotient  input  WIDTH  unsigned quotient from the divider.
- div_remainder  input  WIDTH  unsigned remainder from the divider.
- div_resultRDY  input  1  divider completion pulse; latency is not assumed fixed.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE.
  - All outputs 0: data_quotient, data_remainder, data_exception, data_resultRDY, data_busy, div_start, div_operandA, div_operandB.
  - Reset has priority over ctrl_DIV.
  - Reset mid-operation abandons the operation; any later div_resultRDY is ignored in IDLE.
- States: IDLE, START, WAIT, FIX, DONE.
- Cycle-level sequence:
  - ctrl_DIV=1 (any state) at cycle c:
    - Registers signA=A[WIDTH-1] and signB=B[WIDTH-1].
    - Registers magA=|A| and magB=|B|; two's-complement negate when the sign bit is set.
    - |0x80000000| = 0x80000000 unsigned.
  - Next state after ctrl_DIV:
    - B==0: next state DONE; stored quotient=0, remainder=A unchanged, exception=1.
    - Otherwise: next state START.
  - START: div_start=1 for exactly one cycle; div_operandA/B driven from magA/magB; next state WAIT.
  - WAIT: hold operands. On div_resultRDY=1, capture div_quotient/div_remainder; next state FIX.
  - FIX: sign correction, registered into the outputs:
    - quotient = (signA^signB) ? -Q : Q.
    - remainder = signA ? -R : R.
    - exception=0.
    - Next state DONE.
  - DONE: data_resultRDY=1 for one cycle; next state IDLE.
- Result hold: data_quotient, data_remainder and data_exception hold their values until the next DONE or reset.
- Latency:
  - If div_resultRDY is seen at cycle t, data_resultRDY is high at t+2.
  - Divide-by-zero: data_resultRDY is high at c+1.
- Overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 (wraps), remainder 0, exception 0. No separate overflow flag.
- ctrl_DIV while busy:
  - Aborts the current operation and restarts with the new operands. Result registers are not updated by the aborted operation.
  - A div_resultRDY arriving in START is ignored.
  - A div_start is re-issued, which restarts the divider.
- Simultaneous ctrl_DIV and DONE: data_resultRDY still pulses with the old result. The new request is sampled normally and the next state is START or DONE.
- Arithmetic: all negation is WIDTH-bit modulo 2^WIDTH. No carries are kept.

Test Plan:
1. Bench divider model with latency 33 cycles after div_start.
   - A=100, B=7 → q=14, r=2, exc=0.
   - data_resultRDY exactly 2 cycles after div_resultRDY.
   - div_operandA/B stable (100, 7) throughout WAIT.
2. Sign combinations:
   - -100/7 → q=0xFFFFFFF2, r=0xFFFFFFFE.
   - 100/-7 → q=0xFFFFFFF2, r=2.
   - -100/-7 → q=14, r=0xFFFFFFFE.
3. Divide-by-zero: A=0x1234, B=0.
   - div_start never asserted.
   - data_resultRDY at c+1.
   - q=0, r=0x1234, exc=1.
   - Next op 9/3 → q=3, r=0, exc cleared.
4. Overflow and extremes:
   - 0x80000000/0xFFFFFFFF → q=0x80000000, r=0.
   - 0x80000000/2 → q=0xC0000000, r=0.
   - 7/100 → q=0, r=7.
5. Restart: ctrl_DIV (50/5) then ctrl_DIV (81/-9) at WAIT cycle 10.
   - Second div_start issued.
   - Single data_resultRDY with q=0xFFFFFFF7, r=0.
   - No pulse for 50/5.
6. Reset mid-WAIT at cycle 20:
   - Outputs zero next cycle, state IDLE.
   - A stale div_resultRDY 13 cycles later produces no data_resultRDY.
   - Back-to-back requests after reset complete correctly.
